// File: rtl/ps2_key_source_if.sv
// Key-event bus published by ps2_key_source.
//   ps2_key    : {toggle, pressed, extended, code[7:0]}; bit 10 flips once per event
//   byte_valid : one-cycle strobe per good received byte (prefix bytes included)
//   byte_data  : last good received byte, held between strobes
//   frame_err  : one-cycle strobe on a parity or stop-bit error
// master drives the bus (the PS/2 receiver), slave consumes it.
interface ps2_key_source_if;
  logic [10:0] ps2_key;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  modport master (
    output ps2_key,
    output byte_valid,
    output byte_data,
    output frame_err
  );

  modport slave (
    input ps2_key,
    input byte_valid,
    input byte_data,
    input frame_err
  );
endinterface

// File: rtl/ps2_key_source.sv
// PS/2 keyboard receiver producing the 11-bit toggle-format key event word.
// Deserialises raw PS/2 frames, tracks scan-code set 2 prefixes (E0, F0, E1)
// and publishes one ps2_key update per completed key event.
//   clk_sys  : system clock, all logic on the rising edge
//   reset    : synchronous, active-high
//   ps2_clk  : raw asynchronous PS/2 clock pin
//   ps2_data : raw asynchronous PS/2 data pin
//   key_if   : master side of the key-event bus (ps2_key, byte_valid, byte_data, frame_err)
module ps2_key_source #(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 12000
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  ps2_key_source_if.master         key_if
);

  localparam int unsigned FiltW = $clog2(FILTER + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER - 1);
  localparam logic [TmoW-1:0]  TmoLimit = TmoW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Input conditioning
  logic [1:0]       clk_sync_q;
  logic [1:0]       dat_sync_q;
  logic             filt_q;
  logic             filt_prev_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             fall;
  logic             dat_s;

  // Sync flops and filtered clock reset to the idle-high line level so that
  // reset never manufactures a falling edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], ps2_data};
      filt_prev_q <= filt_q;
      if (clk_sync_q[1] != filt_q) begin
        // Accept the new level only after FILTER consecutive differing cycles.
        if (filt_cnt_q == FiltLast) begin
          filt_q     <= clk_sync_q[1];
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + 1'b1;
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  assign fall  = filt_prev_q & ~filt_q;
  assign dat_s = dat_sync_q[1];

  // Frame FSM and prefix decode
  state_e          state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      sr_q;
  logic            par_q;
  logic [TmoW-1:0] tmo_q;
  logic            ext_q;
  logic            brk_q;
  logic [2:0]      skip_q;
  logic [10:0]     key_q;
  logic            byte_valid_q;
  logic [7:0]      byte_data_q;
  logic            frame_err_q;

  function automatic logic is_response(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      skip_q       <= '0;
      key_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall) begin
        // A falling edge always wins over timeout expiry.
        tmo_q <= '0;
        unique case (state_q)
          StIdle: begin
            // A high data level here is a spurious edge, not a start bit.
            if (!dat_s) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            sr_q      <= {dat_s, sr_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= StParity;
            end
          end
          StParity: begin
            par_q   <= dat_s;
            state_q <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            if (dat_s && (^{sr_q, par_q})) begin
              byte_valid_q <= 1'b1;
              byte_data_q  <= sr_q;
              if (skip_q != 3'd0) begin
                // Swallowing the remainder of the Pause sequence.
                skip_q <= skip_q - 3'd1;
              end else if (sr_q == 8'hE0) begin
                ext_q <= 1'b1;
              end else if (sr_q == 8'hF0) begin
                brk_q <= 1'b1;
              end else if (sr_q == 8'hE1) begin
                skip_q <= 3'd7;
                ext_q  <= 1'b0;
                brk_q  <= 1'b0;
              end else if (is_response(sr_q)) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
              end else begin
                key_q <= {~key_q[10], ~brk_q, ext_q, sr_q};
                ext_q <= 1'b0;
                brk_q <= 1'b0;
              end
            end else begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
              skip_q      <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q != StIdle) begin
        // Stalled frame: drop the partial byte, leave prefix state alone.
        if (tmo_q == TmoLimit) begin
          state_q <= StIdle;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign key_if.ps2_key    = key_q;
  assign key_if.byte_valid = byte_valid_q;
  assign key_if.byte_data  = byte_data_q;
  assign key_if.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_source.sv
// Self-checking bench for ps2_key_source: bit-bangs PS/2 frames, keeps a
// byte-level model of the prefix decoder and compares every cycle.
module tb_ps2_key_source;

  localparam int unsigned Filter  = 8;
  localparam int unsigned Timeout = 100;
  localparam int          Half    = 15;

  logic clk_sys = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;

  ps2_key_source_if key_if ();

  ps2_key_source #(
    .FILTER  (Filter),
    .TIMEOUT (Timeout)
  ) u_dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_if   (key_if)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [7:0] b;
    logic       good;
  } frame_t;

  frame_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  int tog_cnt = 0;
  logic prev_tog = 1'b0;

  // Model state
  logic [10:0] m_key = '0;
  logic        m_ext = 1'b0;
  logic        m_brk = 1'b0;
  int          m_skip = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_resp(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
           b == 8'hFC || b == 8'hFD || b == 8'hFE || b == 8'hFF;
  endfunction

  task automatic model_step(input frame_t f);
    if (!f.good) begin
      m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (f.b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (f.b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (f.b == 8'hE1) begin
      m_skip = 7; m_ext = 1'b0; m_brk = 1'b0;
    end else if (is_resp(f.b)) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      m_key = {~m_key[10], ~m_brk, m_ext, f.b};
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  // Compare process
  always @(negedge clk_sys) begin
    frame_t f;
    if (reset) begin
      exp_q.delete();
      m_key = '0; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
      prev_tog = 1'b0;
    end else begin
      if (key_if.byte_valid) bv_cnt++;
      if (key_if.frame_err) fe_cnt++;
      if (key_if.ps2_key[10] != prev_tog) tog_cnt++;
      prev_tog = key_if.ps2_key[10];
      if (key_if.byte_valid || key_if.frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {30'd0, key_if.byte_valid, key_if.frame_err}, 32'd0);
        end else begin
          f = exp_q.pop_front();
          chk("strobe_kind", {30'd0, key_if.byte_valid, key_if.frame_err},
              {30'd0, f.good, ~f.good});
          if (f.good) chk("byte_data", {24'd0, key_if.byte_data}, {24'd0, f.b});
          model_step(f);
        end
      end
      chk("ps2_key", {21'd0, key_if.ps2_key}, {21'd0, m_key});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par,
                                           input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(Half);
      ps2_clk = 1'b0;
      wait_cyc(Half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    frame_t f;
    f.b = b;
    f.good = !bad_par && !bad_stop;
    exp_q.push_back(f);
    send_bits(mk_frame(b, bad_par, bad_stop), 11);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    wait_cyc(Filter - 2);
    ps2_clk = 1'b1;
    wait_cyc(20);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      wait_cyc(1);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    wait_cyc(3);
  endtask

  initial begin
    int bv0, fe0, tg0;
    logic [7:0] rb;
    int r;
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(2);
    chk("rst_key", {21'd0, key_if.ps2_key}, 32'd0);
    chk("rst_bv", {31'd0, key_if.byte_valid}, 32'd0);
    chk("rst_bd", {24'd0, key_if.byte_data}, 32'd0);
    chk("rst_fe", {31'd0, key_if.frame_err}, 32'd0);

    // Make code 1C
    bv0 = bv_cnt;
    send_good(8'h1C); drain();
    chk("make_1c", {21'd0, key_if.ps2_key}, 32'h61C);
    chk("make_1c_bv", bv_cnt - bv0, 1);

    // Break 1C
    bv0 = bv_cnt; tg0 = tog_cnt;
    send_good(8'hF0); send_good(8'h1C); drain();
    chk("break_1c", {21'd0, key_if.ps2_key}, 32'h01C);
    chk("break_bv", bv_cnt - bv0, 2);
    chk("break_tog", tog_cnt - tg0, 1);

    // Extended make and break
    send_good(8'hE0); send_good(8'h75); drain();
    chk("ext_make", {21'd0, key_if.ps2_key}, 32'h775);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75); drain();
    chk("ext_break", {21'd0, key_if.ps2_key}, 32'h175);

    // Parity error clears the pending E0
    fe0 = fe_cnt;
    send_good(8'hE0); send_frame(8'h29, 1'b1, 1'b0); send_good(8'h1C); drain();
    chk("perr_fe", fe_cnt - fe0, 1);
    chk("perr_key", {21'd0, key_if.ps2_key}, 32'h61C);

    // Partial frame abandoned by timeout
    fe0 = fe_cnt;
    send_bits(mk_frame(8'h55, 1'b0, 1'b0), 5);
    wait_cyc(Timeout + 40);
    send_good(8'h16); drain();
    chk("tmo_fe", fe_cnt - fe0, 0);
    chk("tmo_key", {21'd0, key_if.ps2_key}, 32'h216);

    // Pause sequence, glitch, then a make
    bv0 = bv_cnt; tg0 = tog_cnt;
    glitch();
    send_good(8'hE1); send_good(8'h14); send_good(8'h77); send_good(8'hE1);
    send_good(8'hF0); send_good(8'h14); send_good(8'hF0); send_good(8'h77);
    send_good(8'h1C); drain();
    chk("pause_bv", bv_cnt - bv0, 9);
    chk("pause_tog", tog_cnt - tg0, 1);
    chk("pause_key", {21'd0, key_if.ps2_key}, 32'h61C);

    // Reset in the middle of a frame
    send_bits(mk_frame(8'h33, 1'b0, 1'b0), 4);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(20);
    chk("midrst_key", {21'd0, key_if.ps2_key}, 32'd0);
    send_good(8'h1C); drain();
    chk("midrst_make", {21'd0, key_if.ps2_key}, 32'h61C);

    // Randomised traffic
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1: rb = 8'hE0;
        2, 3: rb = 8'hF0;
        4:    rb = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'h5A;
        5:    rb = ($urandom_range(0, 1) == 0) ? 8'hFA : 8'hAA;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      r = $urandom_range(0, 19);
      if (r == 0) begin
        send_bits(mk_frame(rb, 1'b0, 1'b0), $urandom_range(1, 10));
        wait_cyc(Timeout + 40);
      end else begin
        send_frame(rb, r == 1, r == 2);
      end
      if ($urandom_range(0, 9) == 0) glitch();
      wait_cyc($urandom_range(0, 40));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/ps2_key_source.md
# ps2_key_source

Producer side of the 11-bit `ps2_key` keyboard event word consumed by the core's key-decode logic. It deserialises raw PS/2 keyboard frames and tracks the scan-code set 2 prefix sequences (E0, F0, E1). Each completed key event is published in toggle format: bit 10 flips, bit 9 is pressed, bit 8 is extended, and bits 7:0 are the code. It sits between the board PS/2 pins and any logic that edge-detects `ps2_key[10]`.

## Interface
- `FILTER`, 8: number of consecutive `clk_sys` cycles the synchronised `ps2_clk` must hold a level before the filtered clock accepts it.
- `TIMEOUT`, 12000: idle `clk_sys` cycles allowed between falling edges inside a frame (about 1 ms at 12 MHz) before the frame is aborted.
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw, asynchronous PS/2 clock pin.
- `ps2_data`  in  1  raw, asynchronous PS/2 data pin.
- `ps2_key`  out  11  {toggle, pressed, extended, code[7:0]}.
- `byte_valid`  out  1  one-cycle strobe for every byte received with a good frame, including prefix bytes.
- `byte_data`  out  8  raw received byte; valid while `byte_valid` is high, held otherwise.
- `frame_err`  out  1  one-cycle strobe on a parity or stop-bit error.

## Operation
- **Input conditioning**
  - Both pins pass through a 2-FF synchroniser.
  - The filtered clock changes only after the synchronised `ps2_clk` has differed from it for FILTER consecutive cycles.
  - A falling edge of the filtered clock gives a one-cycle `fall` pulse. `ps2_data` (synchronised) is sampled on that cycle.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, if data = 0, go to DATA with the bit count cleared. If data = 1, stay in IDLE (spurious edge, no error).
  - DATA: shift 8 bits in, LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: on `fall`, the frame is good if data = 1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity). Return to IDLE either way.
- **Timeout**
  - A counter clears on every `fall` and counts while the FSM is not in IDLE.
  - When it reaches TIMEOUT, the FSM goes to IDLE and the partial byte is discarded. No `frame_err`, prefix flags untouched.
- **Bad frame:** pulse `frame_err`, clear the `ext`, `brk` and skip state, and emit no event.
- **Good frame:** pulse `byte_valid` with `byte_data`, then decode:
  - While skip count > 0: decrement it; no event.
  - 0xE0: set `ext`.
  - 0xF0: set `brk`.
  - 0xE1: skip count = 7, clear `ext`/`brk`. The Pause sequence produces no event.
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFD, 0xFE, 0xFF: device responses. Clear `ext`/`brk`; no event.
  - Any other byte: `ps2_key <= {~ps2_key[10], ~brk, ext, byte}`, then clear `ext`/`brk`.
- **Reset values:** `ps2_key` = 0, `byte_valid` = 0, `byte_data` = 0, `frame_err` = 0, FSM = IDLE, all flags and counters = 0.
- Reset asserted mid-frame aborts the frame; the next frame must begin with a fresh start bit.

## Timing
- Filter latency: the filtered clock falls 2 + FILTER cycles after the raw pin falls (steady input).
- `byte_valid`, `frame_err` and the `ps2_key` update are all registered one cycle after the STOP-state `fall` cycle.
- `ps2_key[10]` toggles exactly once per emitted event and never on prefix, skipped or error bytes.
- `ps2_key` holds its value between events.
- `fall` and timeout expiry on the same cycle: `fall` wins, so the counter clears and the bit is accepted.
- Back-to-back frames need no idle gap beyond the line's own stop-to-start spacing.

## Test plan
- Frame 0x1C, parity 0, stop 1, after reset → `byte_valid` once with `byte_data` = 0x1C; `ps2_key` = 0x61C one cycle after the stop edge.
- Then F0, 1C → `byte_valid` twice; `ps2_key` = 0x01C; exactly one toggle.
- E0 75, then E0 F0 75, from `ps2_key[10]` = 0 → 0x775, then 0x175; no `ps2_key` change on the prefix bytes.
- E0, then 0x29 with a flipped parity bit, then 1C → `frame_err` one cycle; `ps2_key` unchanged by the bad frame; final `ps2_key` has extended = 0 and code 0x1C.
- 5 bits of a frame, then idle for TIMEOUT+1 cycles, then a full 0x16 frame → no `frame_err`; `ps2_key` code = 0x16, pressed = 1.
- E1 14 77 E1 F0 14 F0 77 followed by 0x1C, plus a `ps2_clk` glitch low for FILTER−2 cycles while in IDLE → the glitch is ignored; 9 `byte_valid` pulses; exactly one event, 0x1C pressed.
